// File: rtl/jtag_bridge_pkg.sv
// Shared types and helpers for the JTAG user-DR to system-bus bridge.
package jtag_bridge_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    // Status bit offsets above the response word in the captured DR image
    localparam int unsigned STAT_OVF_BIT  = 0;
    localparam int unsigned STAT_BUSY_BIT = 1;

    // Bit positions inside the synchronised JTAG input bundle
    localparam int unsigned JTAG_IN_W  = 7;
    localparam int unsigned JB_TDI     = 0;
    localparam int unsigned JB_TRESET  = 1;
    localparam int unsigned JB_UPDATE  = 2;
    localparam int unsigned JB_CAPTURE = 3;
    localparam int unsigned JB_SHIFT   = 4;
    localparam int unsigned JB_SEL     = 5;
    localparam int unsigned JB_TCK     = 6;

    function automatic int unsigned dr_len(input int unsigned data_width,
                                           input int unsigned addr_width);
        return 1 + addr_width + data_width;
    endfunction

endpackage

// File: rtl/jtag_sync.sv
// Multi-bit flop-chain synchroniser; each bit is an independent level.
module jtag_sync #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (STAGES < 2) begin : g_bad_stages
        $error("jtag_sync: STAGES must be at least 2");
    end

    logic [WIDTH-1:0] stg [STAGES];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stg[i] <= '0;
            end
        end else begin
            stg[0] <= d;
            for (int i = 1; i < int'(STAGES); i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign q = stg[STAGES-1];

endmodule

// File: rtl/jtag_dr_bridge.sv
// User data register behind BSCAN: shifts {we, addr, data} in, issues it as a
// valid/ready command on UPDATE, and returns {busy, overflow, rsp} on CAPTURE.
module jtag_dr_bridge
    import jtag_bridge_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tck,
    input  logic                  treset,
    input  logic                  sel,
    input  logic                  capture,
    input  logic                  shift,
    input  logic                  update,
    input  logic                  tdi,
    output logic                  tdo,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic                  cmd_we,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic [DATA_WIDTH-1:0] cmd_data,
    input  logic                  rsp_valid,
    input  logic [DATA_WIDTH-1:0] rsp_data
);

    localparam int unsigned L        = dr_len(DATA_WIDTH, ADDR_WIDTH);
    localparam int unsigned OVF_POS  = DATA_WIDTH + STAT_OVF_BIT;
    localparam int unsigned BUSY_POS = DATA_WIDTH + STAT_BUSY_BIT;

    // The busy bit lives in the address field's slot, so it must exist
    if (ADDR_WIDTH < 1) begin : g_bad_addr_width
        $error("jtag_dr_bridge: ADDR_WIDTH must be at least 1");
    end

    logic [JTAG_IN_W-1:0]  jtag_raw;
    logic [JTAG_IN_W-1:0]  jtag_s;
    logic                  tck_hist;
    logic                  tck_act;
    logic                  do_cap;
    logic                  do_shift;
    logic                  do_upd;
    logic                  treset_s;
    logic                  hs;
    state_t                state;
    logic                  overflow;
    logic [L-1:0]          sr;
    logic [L-1:0]          cap_word;
    logic [DATA_WIDTH-1:0] rsp_reg;

    assign jtag_raw = {tck, sel, shift, capture, update, treset, tdi};

    jtag_sync #(
        .WIDTH  (JTAG_IN_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (jtag_raw),
        .q     (jtag_s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tck_hist <= 1'b0;
        end else begin
            tck_hist <= jtag_s[JB_TCK];
        end
    end

    // TAP states are mutually exclusive; capture > shift > update guards glitches
    assign treset_s = jtag_s[JB_TRESET];
    assign tck_act  = jtag_s[JB_TCK] & ~tck_hist & jtag_s[JB_SEL];
    assign do_cap   = tck_act & jtag_s[JB_CAPTURE];
    assign do_shift = tck_act & ~jtag_s[JB_CAPTURE] & jtag_s[JB_SHIFT];
    assign do_upd   = tck_act & ~jtag_s[JB_CAPTURE] & ~jtag_s[JB_SHIFT] & jtag_s[JB_UPDATE];
    assign hs       = cmd_valid & cmd_ready;

    always_comb begin
        cap_word                     = '0;
        cap_word[DATA_WIDTH-1:0]     = rsp_reg;
        cap_word[OVF_POS]            = overflow;
        cap_word[BUSY_POS]           = (state == PEND);
    end

    // Shift register, serial output and response holding register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr      <= '0;
            tdo     <= 1'b0;
            rsp_reg <= '0;
        end else if (treset_s) begin
            sr      <= '0;
            tdo     <= 1'b0;
            rsp_reg <= '0;
        end else begin
            tdo <= sr[0];
            if (do_cap) begin
                sr <= cap_word;
            end else if (do_shift) begin
                sr <= {jtag_s[JB_TDI], sr[L-1:1]};
            end
            if (rsp_valid) begin
                rsp_reg <= rsp_data;
            end
        end
    end

    // Command FSM; an update on the handshake cycle re-arms without a gap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cmd_valid <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_data  <= '0;
            overflow  <= 1'b0;
        end else if (treset_s) begin
            state     <= IDLE;
            cmd_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (do_cap) begin
                overflow <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (do_upd) begin
                        cmd_we    <= sr[L-1];
                        cmd_addr  <= sr[DATA_WIDTH+ADDR_WIDTH-1:DATA_WIDTH];
                        cmd_data  <= sr[DATA_WIDTH-1:0];
                        cmd_valid <= 1'b1;
                        state     <= PEND;
                    end
                end
                PEND: begin
                    if (hs) begin
                        if (do_upd) begin
                            cmd_we   <= sr[L-1];
                            cmd_addr <= sr[DATA_WIDTH+ADDR_WIDTH-1:DATA_WIDTH];
                            cmd_data <= sr[DATA_WIDTH-1:0];
                        end else begin
                            cmd_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end else if (do_upd) begin
                        overflow <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_dr_bridge.sv
// Directed bench for jtag_dr_bridge: drives a slow tck and checks commands and readback.
module tb_jtag_dr_bridge;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 4;
    localparam int unsigned L  = 1 + AW + DW;

    logic          clk;
    logic          reset;
    logic          tck;
    logic          treset;
    logic          sel;
    logic          capture;
    logic          shift;
    logic          update;
    logic          tdi;
    logic          tdo;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;

    int unsigned   n_checks = 0;
    int unsigned   n_errors = 0;
    int unsigned   hs_count = 0;
    logic          hs_we;
    logic [AW-1:0] hs_addr;
    logic [DW-1:0] hs_data;

    jtag_dr_bridge #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tck       (tck),
        .treset    (treset),
        .sel       (sel),
        .capture   (capture),
        .shift     (shift),
        .update    (update),
        .tdi       (tdi),
        .tdo       (tdo),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted command
    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) begin
            hs_count <= hs_count + 1;
            hs_we    <= cmd_we;
            hs_addr  <= cmd_addr;
            hs_data  <= cmd_data;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [L-1:0] mk_cmd(input logic we, input logic [AW-1:0] addr,
                                            input logic [DW-1:0] data);
        return {we, addr, data};
    endfunction

    // One tck period of 16 clk; starts and ends on a falling clk edge
    task automatic tck_cycle();
        tck = 1'b1;
        repeat (8) @(negedge clk);
        tck = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic jtag_capture();
        sel = 1'b1; capture = 1'b1;
        tck_cycle();
        capture = 1'b0;
    endtask

    task automatic jtag_update();
        sel = 1'b1; update = 1'b1;
        tck_cycle();
        update = 1'b0;
    endtask

    task automatic shift_dr(input logic [L-1:0] din, output logic [L-1:0] dout);
        sel = 1'b1; shift = 1'b1;
        for (int i = 0; i < int'(L); i++) begin
            dout[i] = tdo;
            tdi     = din[i];
            tck_cycle();
        end
        shift = 1'b0; tdi = 1'b0;
    endtask

    task automatic send_cmd(input logic [L-1:0] cmd);
        logic [L-1:0] junk;
        shift_dr(cmd, junk);
        jtag_update();
    endtask

    task automatic read_dr(output logic [L-1:0] dout);
        jtag_capture();
        shift_dr('0, dout);
    endtask

    initial begin
        logic [L-1:0] dout;
        logic [L-1:0] junk;
        logic [L-1:0] pat;
        int unsigned  base;
        int unsigned  drops;

        reset = 1'b0; tck = 1'b0; treset = 1'b0; sel = 1'b0; capture = 1'b0;
        shift = 1'b0; update = 1'b0; tdi = 1'b0; cmd_ready = 1'b0;
        rsp_valid = 1'b0; rsp_data = '0;
        repeat (5) @(negedge clk);
        check_eq("rst_tdo", 64'(tdo), 64'h0);
        check_eq("rst_valid", 64'(cmd_valid), 64'h0);
        check_eq("rst_data", 64'(cmd_data), 64'h0);
        check_eq("rst_addr_we", 64'({cmd_we, cmd_addr}), 64'h0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // 1: write command accepted immediately
        cmd_ready = 1'b1;
        send_cmd(mk_cmd(1'b1, 4'h5, 32'hDEADBEEF));
        check_eq("t1_hs_count", 64'(hs_count), 64'd1);
        check_eq("t1_we", 64'(hs_we), 64'h1);
        check_eq("t1_addr", 64'(hs_addr), 64'h5);
        check_eq("t1_data", 64'(hs_data), 64'hDEADBEEF);
        check_eq("t1_valid_low", 64'(cmd_valid), 64'h0);

        // 2: response readback
        rsp_data = 32'h12345678; rsp_valid = 1'b1;
        @(negedge clk);
        rsp_valid = 1'b0; rsp_data = '0;
        read_dr(dout);
        check_eq("t2_rsp", 64'(dout[31:0]), 64'h12345678);
        check_eq("t2_ovf", 64'(dout[32]), 64'h0);
        check_eq("t2_busy", 64'(dout[33]), 64'h0);
        check_eq("t2_upper", 64'(dout[36:34]), 64'h0);

        // 3: second update while pending overflows
        cmd_ready = 1'b0;
        send_cmd(mk_cmd(1'b0, 4'h3, 32'h11111111));
        send_cmd(mk_cmd(1'b1, 4'h7, 32'h22222222));
        check_eq("t3_valid", 64'(cmd_valid), 64'h1);
        check_eq("t3_cmd", 64'({cmd_we, cmd_addr, cmd_data}), 64'h0_3111_11111);
        read_dr(dout);
        check_eq("t3_cap1", 64'(dout), 64'h3_1234_5678);
        read_dr(dout);
        check_eq("t3_cap2", 64'(dout), 64'h2_1234_5678);
        cmd_ready = 1'b1;
        repeat (4) @(negedge clk);
        cmd_ready = 1'b0;
        check_eq("t3_hs_count", 64'(hs_count), 64'd2);
        check_eq("t3_hs_data", 64'(hs_data), 64'h11111111);
        check_eq("t3_valid_low", 64'(cmd_valid), 64'h0);

        // 4: update lands exactly on the handshake cycle
        send_cmd(mk_cmd(1'b1, 4'hA, 32'hA5A5A5A5));
        shift_dr(mk_cmd(1'b0, 4'hC, 32'h0F0F0F0F), junk);
        base = hs_count;
        drops = 0;
        sel = 1'b1; update = 1'b1; tck = 1'b1;
        @(negedge clk);
        if (!cmd_valid) drops++;
        @(negedge clk);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        for (int i = 0; i < 13; i++) begin
            if (!cmd_valid) drops++;
            @(negedge clk);
        end
        tck = 1'b0; update = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!cmd_valid) drops++;
            @(negedge clk);
        end
        check_eq("t4_hs_count", 64'(hs_count), 64'(base + 1));
        check_eq("t4_hs_data", 64'(hs_data), 64'hA5A5A5A5);
        check_eq("t4_valid_gap", 64'(drops), 64'h0);
        check_eq("t4_cmd", 64'({cmd_we, cmd_addr, cmd_data}), 64'h0_C0F0F0F0F);
        read_dr(dout);
        check_eq("t4_cap", 64'(dout), 64'h2_1234_5678);
        cmd_ready = 1'b1;
        repeat (4) @(negedge clk);
        cmd_ready = 1'b0;
        check_eq("t4_hs_count2", 64'(hs_count), 64'(base + 2));
        check_eq("t4_hs_data2", 64'(hs_data), 64'h0F0F0F0F);

        // 5: test-logic reset mid-shift with a pending command
        send_cmd(mk_cmd(1'b1, 4'h1, 32'h33333333));
        check_eq("t5_valid_pre", 64'(cmd_valid), 64'h1);
        shift_dr({L{1'b1}}, junk);
        check_eq("t5_tdo_pre", 64'(tdo), 64'h1);
        sel = 1'b1; shift = 1'b1; treset = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("t5_valid", 64'(cmd_valid), 64'h0);
        check_eq("t5_tdo", 64'(tdo), 64'h0);
        treset = 1'b0; shift = 1'b0;
        repeat (4) @(negedge clk);
        shift_dr('0, dout);
        check_eq("t5_sr", 64'(dout), 64'h0);
        read_dr(dout);
        check_eq("t5_cap", 64'(dout), 64'h0);

        // 6: deselected tck edges are ignored
        pat = 37'h1_C3A5_5A3D;
        shift_dr(pat, junk);
        check_eq("t6_tdo_pre", 64'(tdo), 64'h1);
        sel = 1'b0; shift = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tdi = 1'(i);
            tck_cycle();
        end
        shift = 1'b0; tdi = 1'b0;
        check_eq("t6_tdo_hold", 64'(tdo), 64'h1);
        shift_dr('0, dout);
        check_eq("t6_sr_hold", 64'(dout), 64'(pat));

        // 6b: async reset while a command is pending
        cmd_ready = 1'b0;
        send_cmd(mk_cmd(1'b1, 4'h9, 32'hCAFEF00D));
        check_eq("t6_valid_pre", 64'(cmd_valid), 64'h1);
        base = hs_count;
        reset = 1'b0;
        #1;
        check_eq("t6_rst_valid", 64'(cmd_valid), 64'h0);
        check_eq("t6_rst_cmd", 64'({cmd_we, cmd_addr, cmd_data}), 64'h0);
        check_eq("t6_rst_tdo", 64'(tdo), 64'h0);
        repeat (3) @(negedge clk);
        check_eq("t6_no_hs", 64'(hs_count), 64'(base));
        reset = 1'b1;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/jtag_dr_bridge.md
Name: jtag_dr_bridge

Overview:
- Parametrised user data register that sits behind the Jtag BSCAN wrapper. It connects to the Jtag_if tap-side signals, oversampled in the system clock domain.
- Implements one LSB-first shift register of length L = 1 + ADDR_WIDTH + DATA_WIDTH.
- On UPDATE it issues a {we, addr, data} command to system logic over a valid/ready handshake.
- On CAPTURE it loads the last response word and status flags so the host can read them back.
- Successor to the fixed-function TAP hookup: generalised width/address space, with flow control and overflow reporting.

Parameters:
- DATA_WIDTH, 32, payload width of command and response.
- ADDR_WIDTH, 4, command address field width.
- SYNC_STAGES, 2, synchroniser depth for tck/sel/shift/capture/update/treset/tdi, minimum 2.

Ports:
- clk  in  1  system clock; must be at least 8x tck frequency.
- reset  in  1  asynchronous, active-low reset.
- tck  in  1  JTAG DRCK from BSCAN.
- treset  in  1  JTAG test-logic reset, active high.
- sel  in  1  user chain selected.
- capture  in  1  CAPTURE-DR.
- shift  in  1  SHIFT-DR.
- update  in  1  UPDATE-DR.
- tdi  in  1  serial in.
- tdo  out  1  serial out, driven from clk domain.
- cmd_valid  out  1  command available.
- cmd_ready  in  1  system accepts command.
- cmd_we  out  1  1 = write, 0 = read.
- cmd_addr  out  ADDR_WIDTH  command address.
- cmd_data  out  DATA_WIDTH  write data.
- rsp_valid  in  1  response strobe, single cycle.
- rsp_data  in  DATA_WIDTH  response word.

Behaviour:
- Reset (reset = 0) clears:
  - sr, tdo, cmd_valid, cmd_we, cmd_addr, cmd_data, rsp_reg, overflow: all 0.
  - FSM = IDLE.
  - Synchroniser flops: 0.
- All JTAG inputs pass through SYNC_STAGES flops, plus one history flop on tck.
- tck_rise = synced tck & ~history. All JTAG actions happen only in a cycle with tck_rise & sel, using the synced control levels.
- Capture: sr <= {zeros, busy, overflow, rsp_reg}.
  - bits [DATA_WIDTH-1:0] = rsp_reg.
  - bit DATA_WIDTH = overflow.
  - bit DATA_WIDTH+1 = busy (FSM == PEND).
  - Remaining upper bits 0. Requires ADDR_WIDTH >= 1; elaboration error otherwise.
  - overflow is cleared in the same cycle as the capture (read-to-clear).
- Shift: sr <= {tdi_sync, sr[L-1:1]}.
- tdo is a register equal to sr[0], updated in the cycle after each sr change. The host samples on the falling tck edge, so latency is at most SYNC_STAGES+2 clk after the rising edge.
- Update field mapping: sr[DATA_WIDTH-1:0] = data; sr[DATA_WIDTH+ADDR_WIDTH-1:DATA_WIDTH] = addr; sr[L-1] = we.
- FSM IDLE:
  - On update, latch the fields into cmd_*, assert cmd_valid next cycle, go to PEND.
- FSM PEND:
  - cmd_valid stays high and cmd_* stay stable until cmd_valid & cmd_ready.
  - Then deassert cmd_valid next cycle and go to IDLE.
  - An update while in PEND discards the new command and sets overflow = 1. cmd_* are unchanged.
- Update coinciding with the handshake cycle: the handshake completes, the new command is latched, and the FSM stays in PEND with cmd_valid held high. No overflow.
- Responses: rsp_valid loads rsp_reg in any state. If rsp_valid coincides with a capture, the capture loads the old rsp_reg and rsp_reg then takes the new value.
- treset (synced, level): behaves as a synchronous clear of sr, rsp_reg, overflow and the FSM (cmd_valid drops) while high. tdo = 0.
- If sel is low, tck edges are ignored and sr holds its value.
- Async reset mid-command drops the pending command without a handshake.

Decomposition:
- Package jtag_bridge_pkg:
  - typedef enum {IDLE, PEND} state_t.
  - Bit-position constants: STAT_OVF_BIT = DATA_WIDTH offset, STAT_BUSY_BIT.
  - Function dr_len(DATA_WIDTH, ADDR_WIDTH).
- Sub-module jtag_sync: parametrised SYNC_STAGES multi-bit synchroniser with async active-low reset, instantiated once for the 7-bit JTAG input bundle.

Test Plan:
1. Write command: DATA_WIDTH=32, ADDR_WIDTH=4, shift 37 bits {we=1, addr=0x5, data=0xDEADBEEF}, then update, cmd_ready=1 -> one cmd_valid pulse with cmd_we=1, cmd_addr=0x5, cmd_data=0xDEADBEEF; FSM back to IDLE.
2. Readback: rsp_valid with rsp_data=0x12345678, then capture and shift 37 bits -> first 32 tdo bits LSB-first = 0x12345678, then overflow=0, busy=0, rest 0.
3. Overflow: cmd_ready=0, two update sequences -> cmd_data holds the first command; the next capture shows overflow=1 and busy=1; a second capture shows overflow=0.
4. Back-to-back update on the handshake cycle -> the second command is presented with cmd_valid continuously high; overflow=0.
5. treset asserted mid-shift with a pending command -> cmd_valid=0, sr cleared, next capture returns all zeros.
6. sel=0 while tck toggles with shift=1 -> sr and tdo unchanged; async reset asserted during PEND -> all outputs 0 immediately.
